counter_sequencer: RTL
======================

# counter_sequencer

Command-driven controller that owns and sequences a WIDTH-bit up-counter. It accepts START/STOP/RESUME/CLEAR commands over a valid/ready handshake and counts from 0 to a programmable limit. At the limit it signals completion, then either reloads (periodic mode) or holds (one-shot mode). It sits between a control master, such as a bench, CPU-style register block or sequencer, and any logic that consumes the count value or the terminal-count pulse.

## Interface
- WIDTH, 4, counter and limit width in bits (≥ 2)
- clock  input  1  single clock; all state changes on posedge
- reset  input  1  synchronous, active-high; sampled on posedge clock
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command this cycle
- cmd_op  input  2  00 START, 01 STOP (pause), 10 RESUME, 11 CLEAR
- cmd_limit  input  WIDTH  terminal value; sampled only on an accepted START
- cmd_reload  input  1  1 = periodic, 0 = one-shot; sampled only on an accepted START
- out  output  WIDTH  current count (registered)
- busy  output  1  high in RUN or PAUSED
- done  output  1  one-cycle terminal-count pulse (registered)

## Operation
- A command is accepted on a posedge where cmd_valid && cmd_ready.
- cmd_ready is registered:
  - It drops to 0 for exactly the one cycle following any accepted command.
  - It is 1 otherwise.
  - This enforces at most one command every two cycles.
- The controller latches limit_q and reload_q on an accepted START only.
- States: IDLE, RUN, PAUSED, HOLD.
- IDLE (out = 0):
  - START → RUN, out ← 0.
  - STOP, RESUME and CLEAR are accepted with no effect.
- RUN:
  - Each cycle with no accepted command: if out == limit_q, done ← 1. Then, if reload_q, out ← 0 and the state stays RUN; otherwise out holds and the state becomes HOLD.
  - Each cycle with no accepted command where out ≠ limit_q: out ← out + 1.
  - STOP → PAUSED, out holds.
  - START restarts the count: new limit/reload latched, out ← 0.
  - RESUME is ignored.
  - CLEAR → IDLE, out ← 0.
- PAUSED:
  - out holds.
  - RESUME → RUN; counting continues from the held value.
  - START restarts, exactly as in RUN.
  - CLEAR → IDLE.
  - STOP is ignored.
- HOLD:
  - out = limit_q, busy = 0.
  - START restarts.
  - CLEAR → IDLE.
  - STOP and RESUME are ignored.
- Arithmetic and width rules:
  - The increment is modulo 2^WIDTH, but out never exceeds limit_q, so it never wraps.
  - limit = 2^WIDTH−1 is legal.
- limit = 0:
  - One-shot: done pulses on the first RUN cycle evaluation, then HOLD with out = 0.
  - Periodic: done is high every cycle and out stays 0.
- Simultaneous events: an accepted command takes priority over terminal-count evaluation in the same cycle. That cycle's done pulse is suppressed.
- Reset:
  - Effect: state ← IDLE, out ← 0, done ← 0, busy ← 0, cmd_ready ← 1.
  - Priority: reset overrides any command in the same cycle.
  - Reset mid-count or mid-pause produces no done pulse.

## Timing
- START accepted at edge k: out = 0 and busy = 1 after edge k.
  - out = n after edge k+n, for n ≤ L.
- done = 1 only during the cycle after edge k+L+1.
  - Periodic mode: out = 0 in that cycle. Period is L+1 cycles.
  - One-shot mode: out = L in that cycle and busy = 0.
- STOP accepted at edge j: out after edge j equals out before edge j (no increment on the accepting edge).
- RESUME accepted at edge r: out holds after edge r; the first increment occurs at edge r+1.
- All outputs are registered. There is no combinational path from cmd_* to any output.

## Test plan
- Reset, then START with limit = 5, reload = 0.
  - Required: out goes 0,1,2,3,4,5 on successive cycles.
  - Required: done pulses once in the cycle after out first reads 5, with out = 5 and busy = 0.
  - Required: out stays at 5 for 10 further cycles.
- START with limit = 3, reload = 1.
  - Required: out follows 0,1,2,3,0,1,2,3.
  - Required: done is high exactly in the cycles where out returns to 0 (every 4 cycles).
- START with limit = 9; STOP when out = 4.
  - Required: out holds at 4 for 6 cycles and busy stays 1.
  - Then RESUME. Required: out holds 4 for one more cycle, then 5…9, then one done pulse.
- Issue STOP in the same cycle that out = limit in periodic mode.
  - Required: no done pulse, state PAUSED, out = limit.
- Hold cmd_valid high for back-to-back commands.
  - Required: cmd_ready alternates 1,0,1,0 and only every other command takes effect.
- Assert reset while out = 6 of limit = 12.
  - Required: the next cycle shows out = 0, busy = 0, done = 0, cmd_ready = 1.
  - Required: no done pulse ever occurs without a new START.
- Corner case: START with limit = 0 in both modes.
  - Required: behaviour exactly as defined under Operation.

Source files
------------

// File: rtl/counter_sequencer.sv
// counter_sequencer: command-driven owner of a WIDTH-bit up-counter.
// Counts from 0 to a limit latched at START, then pulses done.
// In periodic mode it reloads to 0; in one-shot mode it holds at the limit.
// Every output is registered, so no cmd_* input reaches an output combinationally.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | no count in progress, out = 0
// RUN     | counting toward limit_q, one step per cycle
// PAUSED  | count frozen by STOP, waiting for RESUME/START/CLEAR
// HOLD    | one-shot count finished, out parked at limit_q
module counter_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic             cmd_reload,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_STOP   = 2'b01;
  localparam logic [1:0] OP_RESUME = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] limit_q;
  logic             reload_q;
  logic [WIDTH-1:0] out_nxt;
  logic             done_nxt;
  logic             busy_nxt;
  logic             cmd_accept;
  logic             at_limit;
  logic             is_start;
  logic             is_stop;
  logic             is_resume;
  logic             is_clear;

  // Decode of the accepted command; a command only counts on a handshake.
  always_comb begin
    cmd_accept = cmd_valid && cmd_ready;
    at_limit   = (out == limit_q);
    is_start   = cmd_accept && (cmd_op == OP_START);
    is_stop    = cmd_accept && (cmd_op == OP_STOP);
    is_resume  = cmd_accept && (cmd_op == OP_RESUME);
    is_clear   = cmd_accept && (cmd_op == OP_CLEAR);
  end

  // State register plus the registered outputs and START-time configuration.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      out       <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
      limit_q   <= '0;
      reload_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      out       <= out_nxt;
      done      <= done_nxt;
      busy      <= busy_nxt;
      // Ready drops for exactly the cycle after an accepted command.
      cmd_ready <= !cmd_accept;
      if (is_start) begin
        limit_q  <= cmd_limit;
        reload_q <= cmd_reload;
      end
    end
  end

  // Next-state selection; accepted commands take priority over terminal count.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (is_start) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (is_start)                      state_nxt = S_RUN;
        else if (is_stop)                  state_nxt = S_PAUSED;
        else if (is_clear)                 state_nxt = S_IDLE;
        else if (is_resume)                state_nxt = S_RUN;
        else if (at_limit && !reload_q)    state_nxt = S_HOLD;
      end
      S_PAUSED: begin
        if (is_start || is_resume)         state_nxt = S_RUN;
        else if (is_clear)                 state_nxt = S_IDLE;
      end
      S_HOLD: begin
        if (is_start)                      state_nxt = S_RUN;
        else if (is_clear)                 state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    out_nxt  = out;
    done_nxt = 1'b0;
    busy_nxt = (state_nxt == S_RUN) || (state_nxt == S_PAUSED);
    if (is_start || is_clear) begin
      // Both restart and clear return the count to zero from any state.
      out_nxt = '0;
    end else begin
      case (state)
        S_IDLE: out_nxt = '0;
        S_RUN: begin
          // A RESUME while running is a no-op, but it still occupies the
          // handshake slot, so that cycle neither counts nor evaluates.
          if (!cmd_accept) begin
            if (at_limit) begin
              done_nxt = 1'b1;
              if (reload_q) out_nxt = '0;
            end else begin
              // Never wraps: out is capped by limit_q before overflowing.
              out_nxt = out + WIDTH'(1);
            end
          end
        end
        S_PAUSED: out_nxt = out;
        S_HOLD:   out_nxt = out;
        default:  out_nxt = '0;
      endcase
    end
  end

endmodule
